// File: rtl/seq_impl_checker_if.sv
// rtl/seq_impl_checker_if.sv - stimulus/result bundle for seq_impl_checker
// Purpose: groups the sequence checker's control, event inputs and result
//   outputs so the checker and its driver connect through one port.
// Signals:
//   clr                    - synchronous clear of all counters
//   mode[NCH]              - per channel: 0 = implication, 1 = followed-by
//   a[NCH], b[NCH]         - antecedent / consequent signals
//   pass/fail/vac[NCH]     - one-cycle result pulses
//   busy[NCH]              - channel has unresolved attempts
//   pass/fail/vac_cnt      - saturating per-channel counters, ch0 in LSBs
// Modports: master drives clr/mode/a/b; slave (the checker) drives results.
interface seq_impl_checker_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 16
);
  logic                 clr;
  logic [NCH-1:0]       mode;
  logic [NCH-1:0]       a;
  logic [NCH-1:0]       b;
  logic [NCH-1:0]       pass;
  logic [NCH-1:0]       fail;
  logic [NCH-1:0]       vac;
  logic [NCH-1:0]       busy;
  logic [NCH*CNT_W-1:0] pass_cnt;
  logic [NCH*CNT_W-1:0] fail_cnt;
  logic [NCH*CNT_W-1:0] vac_cnt;

  modport master (
    output clr, mode, a, b,
    input  pass, fail, vac, busy, pass_cnt, fail_cnt, vac_cnt
  );

  modport slave (
    input  clr, mode, a, b,
    output pass, fail, vac, busy, pass_cnt, fail_cnt, vac_cnt
  );
endinterface

// File: rtl/seq_impl_checker.sv
// rtl/seq_impl_checker.sv - multi-channel antecedent/consequent sequence checker
// Purpose: per channel, tracks overlapping antecedent attempts in an age
//   shift register and resolves them against consequent events that fall in
//   the [MIN_DLY..MAX_DLY] window, in implication or followed-by mode.
// Ports:
//   clk    - clock, all logic on posedge
//   rst_n  - asynchronous active-low reset
//   bus    - slave modport: clr/mode/a/b in; pass/fail/vac/busy pulses and
//            saturating pass/fail/vac counters out
module seq_impl_checker #(
  parameter int NCH     = 4,
  parameter int MIN_DLY = 0,
  parameter int MAX_DLY = 0,
  parameter int EDGE    = 1,
  parameter int CNT_W   = 16
) (
  input logic               clk,
  input logic               rst_n,
  seq_impl_checker_if.slave bus
);
  localparam int D  = MAX_DLY + 1;
  localparam int PW = $clog2(MAX_DLY + 2);
  localparam int SW = CNT_W + 6;

  logic [NCH-1:0]   a_prev_q, b_prev_q;
  logic [NCH-1:0]   aev, bev;
  logic [D-1:0]     pend_q [NCH];
  logic [D-1:0]     pend_d [NCH];
  logic [D-1:0]     cur    [NCH];
  logic [D-1:0]     hit    [NCH];
  logic [PW-1:0]    npass  [NCH];
  logic [1:0]       nfail  [NCH];
  logic [NCH-1:0]   pass_d, fail_d, vac_d, busy_d;
  logic [NCH-1:0]   pass_q, fail_q, vac_q, busy_q;
  logic [CNT_W-1:0] pc_q [NCH];
  logic [CNT_W-1:0] fc_q [NCH];
  logic [CNT_W-1:0] vc_q [NCH];
  logic [CNT_W-1:0] pc_d [NCH];
  logic [CNT_W-1:0] fc_d [NCH];
  logic [CNT_W-1:0] vc_d [NCH];

  // Wide sum so the saturation test cannot itself overflow.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                               input logic [4:0]       inc);
    logic [SW-1:0] s;
    s = SW'(c) + SW'(inc);
    if (s > SW'({CNT_W{1'b1}})) return '1;
    return s[CNT_W-1:0];
  endfunction

  always_comb begin
    for (int g = 0; g < NCH; g++) begin
      aev[g] = (EDGE != 0) ? (bus.a[g] & ~a_prev_q[g]) : bus.a[g];
      bev[g] = (EDGE != 0) ? (bus.b[g] & ~b_prev_q[g]) : bus.b[g];
      // Every pending attempt ages by one; a new antecedent enters at age 0.
      cur[g] = (pend_q[g] << 1) | D'(aev[g]);
      hit[g] = '0;
      for (int k = MIN_DLY; k <= MAX_DLY; k++) hit[g][k] = cur[g][k] & bev[g];
      npass[g] = '0;
      for (int k = 0; k < D; k++) npass[g] = npass[g] + PW'(hit[g][k]);
      // The oldest slot fails unless the consequent lands this cycle;
      // followed-by additionally fails a cycle with no antecedent.
      nfail[g]  = {1'b0, cur[g][MAX_DLY] & ~bev[g]} + {1'b0, bus.mode[g] & ~aev[g]};
      vac_d[g]  = ~bus.mode[g] & ~aev[g];
      pass_d[g] = |hit[g];
      fail_d[g] = |nfail[g];
      pend_d[g] = cur[g] & ~hit[g];
      pend_d[g][MAX_DLY] = 1'b0;
      busy_d[g] = |pend_d[g];
      if (bus.clr) begin
        pc_d[g] = '0;
        fc_d[g] = '0;
        vc_d[g] = '0;
      end else begin
        pc_d[g] = sat_add(pc_q[g], 5'(npass[g]));
        fc_d[g] = sat_add(fc_q[g], 5'(nfail[g]));
        vc_d[g] = sat_add(vc_q[g], 5'(vac_d[g]));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_prev_q <= '0;
      b_prev_q <= '0;
      pass_q   <= '0;
      fail_q   <= '0;
      vac_q    <= '0;
      busy_q   <= '0;
      for (int g = 0; g < NCH; g++) begin
        pend_q[g] <= '0;
        pc_q[g]   <= '0;
        fc_q[g]   <= '0;
        vc_q[g]   <= '0;
      end
    end else begin
      a_prev_q <= bus.a;
      b_prev_q <= bus.b;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      vac_q    <= vac_d;
      busy_q   <= busy_d;
      for (int g = 0; g < NCH; g++) begin
        pend_q[g] <= pend_d[g];
        pc_q[g]   <= pc_d[g];
        fc_q[g]   <= fc_d[g];
        vc_q[g]   <= vc_d[g];
      end
    end
  end

  always_comb begin
    bus.pass     = pass_q;
    bus.fail     = fail_q;
    bus.vac      = vac_q;
    bus.busy     = busy_q;
    bus.pass_cnt = '0;
    bus.fail_cnt = '0;
    bus.vac_cnt  = '0;
    for (int g = 0; g < NCH; g++) begin
      bus.pass_cnt[g*CNT_W +: CNT_W] = pc_q[g];
      bus.fail_cnt[g*CNT_W +: CNT_W] = fc_q[g];
      bus.vac_cnt[g*CNT_W +: CNT_W]  = vc_q[g];
    end
  end
endmodule

// File: tb/tb_seq_impl_checker.sv
// tb/tb_seq_impl_checker.sv - directed self-checking bench for seq_impl_checker
module tb_seq_impl_checker;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, rst2, rst3;
  int   checks = 0;
  int   errors = 0;

  seq_impl_checker_if #(.NCH(4), .CNT_W(16)) if0 ();
  seq_impl_checker_if #(.NCH(4), .CNT_W(16)) if1 ();
  seq_impl_checker_if #(.NCH(4), .CNT_W(16)) if2 ();
  seq_impl_checker_if #(.NCH(4), .CNT_W(4))  if3 ();

  seq_impl_checker #(.NCH(4), .MIN_DLY(0), .MAX_DLY(0), .EDGE(1), .CNT_W(16))
    u0 (.clk(clk), .rst_n(rst0), .bus(if0));
  seq_impl_checker #(.NCH(4), .MIN_DLY(1), .MAX_DLY(3), .EDGE(1), .CNT_W(16))
    u1 (.clk(clk), .rst_n(rst1), .bus(if1));
  seq_impl_checker #(.NCH(4), .MIN_DLY(0), .MAX_DLY(2), .EDGE(0), .CNT_W(16))
    u2 (.clk(clk), .rst_n(rst2), .bus(if2));
  seq_impl_checker #(.NCH(4), .MIN_DLY(0), .MAX_DLY(0), .EDGE(1), .CNT_W(4))
    u3 (.clk(clk), .rst_n(rst3), .bus(if3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [5:0] e;
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
    if0.clr = 1'b0; if0.mode = 4'b0010; if0.a = '0; if0.b = '0;
    if1.clr = 1'b0; if1.mode = 4'b0000; if1.a = '0; if1.b = '0;
    if2.clr = 1'b0; if2.mode = 4'b0000; if2.a = '0; if2.b = '0;
    if3.clr = 1'b0; if3.mode = 4'b0001; if3.a = '0; if3.b = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_pulses0", 32'({if0.pass, if0.fail, if0.vac, if0.busy}), 32'd0);
    chk("rst_cnt0", 32'(|{if0.pass_cnt, if0.fail_cnt, if0.vac_cnt}), 32'd0);
    chk("rst_pulses3", 32'({if3.pass, if3.fail, if3.vac, if3.busy}), 32'd0);

    // T1 (ch0 implication) and T2 (ch1 followed-by), both events rise at 3rd negedge
    rst0 = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      e = (i == 4) ? 6'b11_00_00 : 6'b00_10_01;
      chk("t12_pass_fail_vac", 32'({if0.pass[1:0], if0.fail[1:0], if0.vac[1:0]}), 32'(e));
      if (i == 3) begin
        if0.a = 4'b0011;
        if0.b = 4'b0011;
      end
    end
    chk("t1_pass_cnt", 32'(if0.pass_cnt[15:0]), 32'd1);
    chk("t1_fail_cnt", 32'(if0.fail_cnt[15:0]), 32'd0);
    chk("t1_vac_cnt", 32'(if0.vac_cnt[15:0]), 32'd9);
    chk("t2_pass_cnt", 32'(if0.pass_cnt[31:16]), 32'd1);
    chk("t2_fail_cnt", 32'(if0.fail_cnt[31:16]), 32'd9);
    chk("t2_vac_cnt", 32'(if0.vac_cnt[31:16]), 32'd0);
    chk("t1_idle_vac_cnt", 32'(if0.vac_cnt[47:32]), 32'd10);

    // T3: window [1..3]; ch0 passes at age 3, ch1 (b at age 0 only) fails
    rst1 = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      e = {((i == 6) ? 2'b01 : 2'b00), ((i == 6) ? 2'b10 : 2'b00),
           ((i >= 3 && i <= 5) ? 2'b11 : 2'b00)};
      chk("t3_pass_fail_busy", 32'({if1.pass[1:0], if1.fail[1:0], if1.busy[1:0]}), 32'(e));
      if (i == 2) begin
        if1.a = 4'b0011;
        if1.b = 4'b0010;
      end
      if (i == 5) if1.b = 4'b0011;
    end
    chk("t3_ch0_pass_cnt", 32'(if1.pass_cnt[15:0]), 32'd1);
    chk("t3_ch0_fail_cnt", 32'(if1.fail_cnt[15:0]), 32'd0);
    chk("t3_ch0_vac_cnt", 32'(if1.vac_cnt[15:0]), 32'd6);
    chk("t3_ch1_pass_cnt", 32'(if1.pass_cnt[31:16]), 32'd0);
    chk("t3_ch1_fail_cnt", 32'(if1.fail_cnt[31:16]), 32'd1);

    // T6: async reset while an attempt is pending at age 1
    if1.a = '0;
    if1.b = '0;
    @(negedge clk);
    if1.a = 4'b0001;
    repeat (2) @(negedge clk);
    chk("t6_busy_before", 32'(if1.busy[0]), 32'd1);
    #2 rst1 = 1'b0;
    #1;
    chk("t6_rst_pulses", 32'({if1.pass, if1.fail, if1.vac, if1.busy}), 32'd0);
    chk("t6_rst_cnt", 32'(|{if1.pass_cnt, if1.fail_cnt, if1.vac_cnt}), 32'd0);
    if1.a = '0;
    @(negedge clk);
    rst1 = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk("t6_no_fail_busy", 32'({if1.fail, if1.busy}), 32'd0);
    end
    chk("t6_fail_cnt", 32'(if1.fail_cnt[15:0]), 32'd0);

    // T4: level events, window [0..2], three overlapping attempts pass together
    rst2 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 3) chk("t4_busy_pending", 32'({if2.busy[0], if2.pass[0]}), 32'b10);
      if (i == 4) begin
        chk("t4_pass_busy", 32'({if2.busy[0], if2.pass[0], if2.fail[0]}), 32'b010);
        chk("t4_pass_cnt", 32'(if2.pass_cnt[15:0]), 32'd3);
        chk("t4_fail_cnt", 32'(if2.fail_cnt[15:0]), 32'd0);
        chk("t4_vac_cnt", 32'(if2.vac_cnt[15:0]), 32'd1);
      end
      if2.a[0] = (i <= 3);
      if2.b[0] = (i == 3);
    end

    // T5: 4-bit counter saturation, then clear during a failing cycle
    rst3 = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      if (i == 14) chk("t5_fail_cnt_14", 32'(if3.fail_cnt[3:0]), 32'd14);
      if (i == 15) chk("t5_fail_cnt_15", 32'(if3.fail_cnt[3:0]), 32'd15);
      if (i == 20) begin
        chk("t5_fail_cnt_sat", 32'(if3.fail_cnt[3:0]), 32'd15);
        if3.clr = 1'b1;
      end
      if (i == 21) begin
        chk("t5_fail_cnt_clr", 32'(if3.fail_cnt[3:0]), 32'd0);
        chk("t5_fail_pulse_clr", 32'(if3.fail[0]), 32'd1);
        if3.clr = 1'b0;
      end
      if (i == 22) chk("t5_fail_cnt_after", 32'(if3.fail_cnt[3:0]), 32'd1);
    end
    chk("t5_vac_cnt", 32'(if3.vac_cnt[3:0]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
